// File: rtl/ets_stream_pkg.sv
// ets_stream_pkg
//   Shared definitions for the ETS sample stream: data/keep widths, the
//   keep-all constant and the frame sink FSM state encoding.
package ets_stream_pkg;

    localparam int ETS_DATA_W = 32;
    localparam int ETS_KEEP_W = ETS_DATA_W / 8;

    localparam logic [ETS_KEEP_W-1:0] ETS_KEEP_ALL = '1;

    // Frame sink FSM state encoding
    typedef logic [1:0] ets_state_t;

    localparam ets_state_t ST_IDLE  = 2'd0;
    localparam ets_state_t ST_RECV  = 2'd1;
    localparam ets_state_t ST_DRAIN = 2'd2;
    localparam ets_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ets_frame_ram.sv
// ets_frame_ram
//   Simple dual-port frame buffer: one write port, one registered read port.
//   Storage is not reset. A read and a write to the same address in the
//   same cycle return the old contents.
// Ports:
//   clk      - clock, rising edge
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read strobe; rd_data updates on the following edge
//   rd_addr  - read address
//   rd_data  - registered read data
module ets_frame_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ets_frame_sink.sv
// ets_frame_sink
//   AXI-Stream slave that captures one ETS sample frame per arm pulse into
//   a local buffer, reporting length, overflow and keep errors.
// Ports:
//   S_AXIS_aclk    - clock, rising edge
//   S_AXIS_areset  - synchronous active-high reset
//   S_AXIS_t*      - AXI-Stream slave (tvalid/tready/tdata/tlast/tkeep)
//   arm            - pulse: start capture (honoured in IDLE or DONE only)
//   busy           - high while receiving or draining
//   frame_done     - high in DONE
//   frame_len      - words stored for the last frame
//   err_len/err_ovf/err_keep - sticky per-frame error flags
//   rd_en/rd_addr/rd_data/rd_valid - buffer readback, one cycle latency
module ets_frame_sink
    import ets_stream_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int EXP_LEN    = 256
) (
    input  logic                  S_AXIS_aclk,
    input  logic                  S_AXIS_areset,
    input  logic                  S_AXIS_tvalid,
    output logic                  S_AXIS_tready,
    input  logic [ETS_DATA_W-1:0] S_AXIS_tdata,
    input  logic                  S_AXIS_tlast,
    input  logic [ETS_KEEP_W-1:0] S_AXIS_tkeep,
    input  logic                  arm,
    output logic                  busy,
    output logic                  frame_done,
    output logic [DEPTH_LOG2:0]   frame_len,
    output logic                  err_len,
    output logic                  err_ovf,
    output logic                  err_keep,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [ETS_DATA_W-1:0] rd_data,
    output logic                  rd_valid
);

    localparam logic [DEPTH_LOG2:0] FULL_LEN  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] EXP_LEN_W = EXP_LEN[DEPTH_LOG2:0];

    ets_state_t              state;
    ets_state_t              state_nx;
    logic                    accept;
    logic                    arm_ok;
    logic                    wr_en;
    logic [DEPTH_LOG2:0]     len_inc;
    logic [ETS_DATA_W-1:0]   ram_q;

    assign accept  = S_AXIS_tvalid & S_AXIS_tready;
    assign arm_ok  = arm & ((state == ST_IDLE) | (state == ST_DONE));
    assign len_inc = frame_len + 1'b1;
    assign wr_en   = (state == ST_RECV) & accept;

    assign busy       = (state == ST_RECV) | (state == ST_DRAIN);
    assign frame_done = (state == ST_DONE);

    // RAM output register cannot be reset; gate it so rd_data reads zero
    // until a read has actually completed.
    assign rd_data = rd_valid ? ram_q : '0;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: if (arm) state_nx = ST_RECV;
            ST_RECV: begin
                if (accept) begin
                    if (S_AXIS_tlast)
                        state_nx = ST_DONE;
                    else if (len_inc == FULL_LEN)
                        state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: if (accept && S_AXIS_tlast) state_nx = ST_DONE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXIS_aclk) begin
        if (S_AXIS_areset) begin
            state         <= ST_IDLE;
            S_AXIS_tready <= 1'b0;
            frame_len     <= '0;
            err_len       <= 1'b0;
            err_ovf       <= 1'b0;
            err_keep      <= 1'b0;
            rd_valid      <= 1'b0;
        end else begin
            state    <= state_nx;
            // tready follows the next state so it is registered yet lines
            // up with the state it belongs to.
            S_AXIS_tready <= (state_nx == ST_RECV) | (state_nx == ST_DRAIN);
            rd_valid <= rd_en;

            if (arm_ok) begin
                frame_len <= '0;
                err_len   <= 1'b0;
                err_ovf   <= 1'b0;
                err_keep  <= 1'b0;
            end else if (accept) begin
                if (S_AXIS_tkeep != ETS_KEEP_ALL)
                    err_keep <= 1'b1;
                if (state == ST_RECV) begin
                    frame_len <= len_inc;
                    if (S_AXIS_tlast)
                        err_len <= (len_inc != EXP_LEN_W);
                    else if (len_inc == FULL_LEN)
                        err_ovf <= 1'b1;
                end else if (state == ST_DRAIN && S_AXIS_tlast) begin
                    err_len <= 1'b1;
                end
            end
        end
    end

    // Write pointer is the low bits of frame_len: both advance together
    // and frame_len never reaches the full count while still in RECV.
    ets_frame_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (ETS_DATA_W)
    ) u_ram (
        .clk     (S_AXIS_aclk),
        .wr_en   (wr_en),
        .wr_addr (frame_len[DEPTH_LOG2-1:0]),
        .wr_data (S_AXIS_tdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

endmodule

// File: doc/ets_frame_sink.md
ETS_FRAME_SINK -- requirements
Module: ets_frame_sink

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, buffer depth = 2^DEPTH_LOG2 words.
REQ-002 SHALL have parameter EXP_LEN, default 256, expected words per frame (1..2^DEPTH_LOG2).
REQ-003 SHALL have S_AXIS_aclk, in, 1, the only clock; all logic on rising edge.
REQ-004 SHALL have S_AXIS_areset, in, 1, reset: synchronous, active-high.
REQ-005 SHALL have S_AXIS_tvalid  in  1, S_AXIS_tready  out  1, S_AXIS_tdata  in  32, S_AXIS_tlast  in  1, S_AXIS_tkeep  in  4: AXI-Stream slave carrying ETS sample frames.
REQ-006 SHALL have arm, in, 1, single-cycle pulse starting capture of one frame.
REQ-007 SHALL have busy, out, 1, high in RECV or DRAIN.
REQ-008 SHALL have frame_done, out, 1, level, high in DONE.
REQ-009 SHALL have frame_len, out, DEPTH_LOG2+1, words stored for the last frame.
REQ-010 SHALL have err_len, out, 1, tlast arrived with frame_len != EXP_LEN.
REQ-011 SHALL have err_ovf, out, 1, buffer filled before tlast.
REQ-012 SHALL have err_keep, out, 1, any accepted beat had tkeep != 4'b1111.
REQ-013 SHALL have rd_en  in  1, rd_addr  in  DEPTH_LOG2, rd_data  out  32, rd_valid  out  1: buffer readback port.

Function
REQ-014 SHALL implement FSM states IDLE, RECV, DRAIN, DONE.
REQ-015 IDLE: tready=0; arm -> RECV, clearing frame_len, err_len, err_ovf, err_keep, write pointer.
REQ-016 RECV: tready=1; each beat with tvalid&tready writes tdata at write pointer, pointer and frame_len +1.
REQ-017 RECV: accepted beat with tlast -> DONE; err_len set same edge if updated frame_len != EXP_LEN.
REQ-018 RECV: accepted non-tlast beat that makes frame_len = 2^DEPTH_LOG2 -> DRAIN, err_ovf set.
REQ-019 Beat with tlast filling the last slot -> DONE, err_ovf not set.
REQ-020 DRAIN: tready=1, beats discarded (no write, frame_len frozen); accepted tlast -> DONE; err_len set.
REQ-021 DONE: tready=0, frame_done=1; arm -> RECV as in REQ-015; frame_done low from next cycle.
REQ-022 arm in RECV or DRAIN SHALL be ignored.
REQ-023 tready SHALL be a registered function of state only, never of tvalid.
REQ-024 err_keep SHALL be sticky per frame; data still stored.
REQ-025 rd_en SHALL return rd_data with rd_valid exactly one cycle later, any state.
REQ-026 Read and write to same address in same cycle SHALL return old data.
REQ-027 rd_addr >= frame_len SHALL return buffer contents without error; content unspecified after reset.
REQ-028 Error flags and frame_len SHALL hold until next arm.

Reset
REQ-029 S_AXIS_areset high SHALL force IDLE next edge, any state, including mid-frame.
REQ-030 Reset values: tready=0, busy=0, frame_done=0, frame_len=0, err_len=0, err_ovf=0, err_keep=0, rd_valid=0, rd_data=0.
REQ-031 Buffer RAM SHALL not be reset.
REQ-032 arm coincident with reset SHALL be ignored.

Structure
REQ-033 Shared package ets_stream_pkg SHALL hold the state enum, ETS data width (32) and keep-all constant.
REQ-034 Buffer SHALL be sub-module ets_frame_ram: simple dual-port, 1 write, 1 registered read, no reset.
REQ-035 FSM, counters and flags SHALL reside in ets_frame_sink.

Verification
REQ-036 Arm, send 256 words 0..255 with tlast on last, tvalid always high -> frame_done=1, frame_len=256, no errors, readback addr k = k.
REQ-037 EXP_LEN=256, tlast on word 100 -> DONE, frame_len=100, err_len=1, err_ovf=0.
REQ-038 300 words, tlast on 300th -> DRAIN after 256, frame_len=256, err_ovf=1, err_len=1, words 257..300 accepted and discarded.
REQ-039 Random tvalid gaps, beat 5 with tkeep=4'b0011 -> all 256 stored in order, err_keep=1.
REQ-040 Reset asserted after word 50 -> tready=0 and busy=0 next cycle; re-arm captures fresh 256-word frame, flags clear.
REQ-041 Stimulus before arm (tvalid=1 in IDLE) -> tready=0, nothing accepted; arm during RECV -> no state change.
